axi_rd_arb: RTL

Round-robin arbiter that shares the single AXI read-address/read-data channel among four in-core read requesters (0: icache refill, 1: dcache refill, 2: uncached load, 3: page-walk/spare). It accepts one request at a time, issues it on AR, routes the R beats back to the owner, and advances the priority pointer after the burst completes. It sits between the cache/LSU miss logic and the AXI bridge. It has exactly one transaction outstanding.

---
 rtl/axi_rd_arb_pkg.sv | 38 +++
 rtl/axi_rd_arb_rr_pick4.sv | 32 +++
 rtl/axi_rd_arb.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the four-port AXI read arbiter.
// Latency: n/a (declarations and pure combinational helpers only).
// Backpressure: n/a.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    localparam int NREQ = 4;

    // Requester slots on the arbiter ports
    localparam logic [1:0] REQ_ICACHE   = 2'd0;
    localparam logic [1:0] REQ_DCACHE   = 2'd1;
    localparam logic [1:0] REQ_UNCACHED = 2'd2;
    localparam logic [1:0] REQ_SPARE    = 2'd3;

    // 4-to-2 encoder for a one-hot vector; all-zero input encodes to 0
    function automatic logic [1:0] enc4to2(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        unique case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // 2-to-4 one-hot decoder
    function automatic logic [3:0] dec2to4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/axi_rd_arb_rr_pick4.sv
// Round-robin picker: lowest set request bit at or after ptr, modulo 4.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is used.
module rr_pick4
    import axi_rd_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       any
);

    logic [7:0] req_dbl;
    logic [7:0] gnt_dbl;
    logic [3:0] rot_req;
    logic [3:0] rot_gnt;
    logic [2:0] back_base;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
    always_comb begin
        req_dbl   = {req, req};
        rot_req   = req_dbl[ptr +: 4];
        rot_gnt   = rot_req & (~rot_req + 4'd1);
        gnt_dbl   = {rot_gnt, rot_gnt};
        back_base = 3'd4 - {1'b0, ptr};
        gnt       = gnt_dbl[back_base +: 4];
        idx       = enc4to2(gnt);
        any       = |req;
    end

endmodule

// File: rtl/axi_rd_arb.sv
// Shares one AXI AR/R channel among four requesters, one burst outstanding.
// Latency: accept in t -> ar_valid in t+1; r_last in u -> next accept in u+1.
// Backpressure: AR fields held until ar_ready; R beats forwarded as r_valid arrives.
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req_valid,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*LEN_W-1:0]    req_len,
    input  logic [11:0]           req_size,
    output logic [3:0]            req_ready,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_W-1:0]     ar_addr,
    output logic [LEN_W-1:0]      ar_len,
    output logic [2:0]            ar_size,
    output logic [3:0]            ar_id,
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic                  r_last,
    input  logic [31:0]           r_data,
    output logic [3:0]            resp_valid,
    output logic                  resp_last,
    output logic [31:0]           resp_data,
    output logic                  busy
);

    state_t              state_q,  state_d;
    logic [1:0]          ptr_q,    ptr_d;
    logic [1:0]          owner_q,  owner_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [LEN_W-1:0]    len_q,    len_d;
    logic [2:0]          size_q,   size_d;

    logic [3:0]          pick_gnt;
    logic [1:0]          pick_idx;
    logic                pick_any;

    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;
    logic [2:0]          sel_size;

    rr_pick4 u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Pull the winning requester's address/len/size out of the flat buses
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_size = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == i[1:0]) begin
                sel_addr = req_addr[ADDR_W*i +: ADDR_W];
                sel_len  = req_len[LEN_W*i +: LEN_W];
                sel_size = req_size[3*i +: 3];
            end
        end
    end

    // Next-state and strobe logic; routing of R beats follows the latched owner
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        req_ready  = 4'b0000;
        resp_valid = 4'b0000;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_gnt;
                    owner_d   = pick_idx;
                    addr_d    = sel_addr;
                    len_d     = sel_len;
                    size_d    = sel_size;
                    state_d   = ST_AR;
                end
            end
            ST_AR: begin
                if (ar_ready) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (r_valid) begin
                    resp_valid = dec2to4(owner_q);
                    if (r_last) begin
                        // The finished owner drops to lowest priority
                        ptr_d   = owner_q + 2'd1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers; reset aborts any burst in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
        end
    end

    assign ar_valid  = (state_q == ST_AR);
    assign r_ready   = (state_q == ST_RD);
    assign busy      = (state_q != ST_IDLE);
    assign ar_addr   = addr_q;
    assign ar_len    = len_q;
    assign ar_size   = size_q;
    assign ar_id     = {2'b00, owner_q};
    assign resp_last = r_last;
    assign resp_data = r_data;

endmodule
